// File: rtl/encoder_msg_arbiter.sv
// Purpose : round-robin share of one AXI-Stream message sink among N_CH monitor streams.
// Latency : a beat accepted on edge t appears on m_tdata/m_tvalid from t+1; 1 beat/cycle sustained.
// Backpressure: while m_tvalid && !m_tready the output register holds and every s_tready is 0.
//
// Ports:
//   clk, reset           - single rising-edge clock, synchronous active-high reset
//   enable_mask[N_CH]    - per-channel permission to compete (disabled channels are stalled)
//   s_tdata/s_tvalid     - per-channel single-beat requests, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tready[N_CH]       - one-hot-or-zero grant, combinational
//   m_tdata/m_tid/m_tvalid/m_tready - registered output beat with its source channel index
//   beat_count[32]       - wrapping count of output handshakes
module encoder_msg_arbiter #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CH-1:0]            enable_mask,
  input  logic [N_CH*DATA_WIDTH-1:0] s_tdata,
  input  logic [N_CH-1:0]            s_tvalid,
  output logic [N_CH-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]      m_tdata,
  output logic [ID_WIDTH-1:0]        m_tid,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [31:0]                beat_count
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [PW-1:0] LAST_CH = PW'(N_CH - 1);
  localparam logic [PW:0]   N_CH_W  = (PW + 1)'(N_CH);

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [ID_WIDTH-1:0]   m_tid_q, m_tid_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic [31:0]           beat_count_q, beat_count_d;

  logic [N_CH-1:0] eligible;
  logic            load_ok;
  logic            gnt_vld;
  logic [PW-1:0]   gnt_idx;
  logic [PW:0]     scan_idx;
  logic            grant_fire;

  assign eligible = s_tvalid & enable_mask;
  assign load_ok  = !m_tvalid_q || m_tready;

  // Rotating scan starting at ptr_q. The sum is one bit wider than the pointer
  // so ptr+k never overflows before the explicit wrap, which keeps the modulo
  // correct for non-power-of-two channel counts.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      scan_idx = {1'b0, ptr_q} + (PW + 1)'(k);
      if (scan_idx >= N_CH_W) begin
        scan_idx = scan_idx - N_CH_W;
      end
      if (!gnt_vld && eligible[scan_idx[PW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx[PW-1:0];
      end
    end
  end

  // Reset gates the grant so a beat is never consumed in a cycle the ORG is cleared.
  assign grant_fire = load_ok && gnt_vld && !reset;
  assign s_tready   = grant_fire ? (N_CH'(1) << gnt_idx) : '0;

  always_comb begin
    ptr_d        = ptr_q;
    m_tdata_d    = m_tdata_q;
    m_tid_d      = m_tid_q;
    m_tvalid_d   = m_tvalid_q;
    beat_count_d = beat_count_q + {31'd0, (m_tvalid_q && m_tready)};
    if (load_ok) begin
      m_tvalid_d = gnt_vld;
      if (gnt_vld) begin
        m_tdata_d = s_tdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        m_tid_d   = ID_WIDTH'(gnt_idx);
        ptr_d     = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      m_tdata_q    <= '0;
      m_tid_q      <= '0;
      m_tvalid_q   <= 1'b0;
      beat_count_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      m_tdata_q    <= m_tdata_d;
      m_tid_q      <= m_tid_d;
      m_tvalid_q   <= m_tvalid_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign m_tdata    = m_tdata_q;
  assign m_tid      = m_tid_q;
  assign m_tvalid   = m_tvalid_q;
  assign beat_count = beat_count_q;

endmodule

// File: tb/tb_encoder_msg_arbiter.sv
module tb_encoder_msg_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic         rst = 1'b1;
  logic [3:0]   en4 = 4'hF;
  logic [255:0] sd4 = '0;
  logic [3:0]   sv4 = '0;
  logic [3:0]   sr4;
  logic [63:0]  md4;
  logic [1:0]   mt4;
  logic         mv4;
  logic         mr4 = 1'b1;
  logic [31:0]  bc4;

  // 3-channel instance
  logic         rst3 = 1'b1;
  logic [2:0]   en3 = 3'h7;
  logic [191:0] sd3 = '0;
  logic [2:0]   sv3 = '0;
  logic [2:0]   sr3;
  logic [63:0]  md3;
  logic [1:0]   mt3;
  logic         mv3;
  logic         mr3 = 1'b1;
  logic [31:0]  bc3;

  int checks = 0;
  int failures = 0;

  encoder_msg_arbiter #(.N_CH(4), .DATA_WIDTH(64), .ID_WIDTH(2)) dut4 (
    .clk(clk), .reset(rst), .enable_mask(en4), .s_tdata(sd4), .s_tvalid(sv4),
    .s_tready(sr4), .m_tdata(md4), .m_tid(mt4), .m_tvalid(mv4), .m_tready(mr4),
    .beat_count(bc4));

  encoder_msg_arbiter #(.N_CH(3), .DATA_WIDTH(64), .ID_WIDTH(2)) dut3 (
    .clk(clk), .reset(rst3), .enable_mask(en3), .s_tdata(sd3), .s_tvalid(sv3),
    .s_tready(sr3), .m_tdata(md3), .m_tid(mt3), .m_tvalid(mv3), .m_tready(mr3),
    .beat_count(bc3));

  // Reference model of the 4-channel instance: output register contents,
  // priority pointer and handshake count, advanced once per rising edge.
  logic        e_vld = 1'b0;
  logic [63:0] e_dat = '0;
  int          e_tid = 0;
  int          e_ptr = 0;
  logic [31:0] e_cnt = '0;
  int          last_g = -1;

  function automatic int m_grant();
    for (int k = 0; k < 4; k++) begin
      int idx = (e_ptr + k) % 4;
      if (sv4[idx] && en4[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_rdy();
    int g;
    if (rst) return 4'b0;
    if (e_vld && !mr4) return 4'b0;
    g = m_grant();
    if (g < 0) return 4'b0;
    return 4'b0001 << g;
  endfunction

  // Advances clock and model; the granted channel then presents fresh data.
  task automatic tick4();
    int g;
    @(posedge clk);
    last_g = -1;
    if (rst) begin
      e_vld = 1'b0; e_dat = '0; e_tid = 0; e_ptr = 0; e_cnt = '0;
    end else begin
      if (e_vld && mr4) e_cnt = e_cnt + 32'd1;
      if (!e_vld || mr4) begin
        g = m_grant();
        if (g >= 0) begin
          e_vld = 1'b1; e_dat = sd4[g*64 +: 64]; e_tid = g; e_ptr = (g + 1) % 4; last_g = g;
        end else begin
          e_vld = 1'b0;
        end
      end
    end
    #1;
    if (last_g >= 0) sd4[last_g*64 +: 64] = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick4();
    tick4();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sv4 = 4'hF; en4 = 4'hF; mr4 = 1'b1;
    #1;
    checks++;
    if (sr4 !== 4'b0) begin failures++; $display("FAIL reset_s_tready got=%b exp=0000", sr4); end
    tick4();
    tick4();
    checks++;
    if (mv4 !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid got=%b exp=0", mv4); end
    checks++;
    if (md4 !== 64'd0) begin failures++; $display("FAIL reset_m_tdata got=%h exp=0", md4); end
    checks++;
    if (mt4 !== 2'd0) begin failures++; $display("FAIL reset_m_tid got=%0d exp=0", mt4); end
    checks++;
    if (bc4 !== 32'd0) begin failures++; $display("FAIL reset_beat_count got=%0d exp=0", bc4); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    sv4 = 4'b0100; en4 = 4'hF; mr4 = 1'b1;
    sd4[2*64 +: 64] = 64'hA5;
    #1;
    checks++;
    if (sr4 !== 4'b0100) begin failures++; $display("FAIL single_s_tready got=%b exp=0100", sr4); end
    tick4();
    sv4 = 4'b0000;
    checks++;
    if (mv4 !== 1'b1 || md4 !== 64'hA5 || mt4 !== 2'd2) begin
      failures++; $display("FAIL single_out got vld=%b dat=%h tid=%0d exp vld=1 dat=a5 tid=2", mv4, md4, mt4);
    end
    tick4();
    checks++;
    if (bc4 !== 32'd1 || mv4 !== 1'b0) begin
      failures++; $display("FAIL single_count got cnt=%0d vld=%b exp cnt=1 vld=0", bc4, mv4);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    sv4 = 4'hF; en4 = 4'hF; mr4 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick4();
      checks++;
      if (mv4 !== 1'b1 || mt4 !== 2'(k % 4) || md4 !== e_dat) begin
        failures++;
        $display("FAIL rr_seq[%0d] got vld=%b tid=%0d dat=%h exp vld=1 tid=%0d dat=%h", k, mv4, mt4, md4, k % 4, e_dat);
      end
    end
    checks++;
    if (bc4 !== 32'd11) begin failures++; $display("FAIL rr_count got=%0d exp=11", bc4); end
    sv4 = 4'h0;
  endtask

  task automatic test_backpressure();
    do_reset();
    sv4 = 4'b0010; mr4 = 1'b0; en4 = 4'hF;
    sd4[1*64 +: 64] = 64'h1234;
    tick4();
    sv4 = 4'b1001;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (sr4 !== 4'b0 || mv4 !== 1'b1 || md4 !== 64'h1234 || mt4 !== 2'd1) begin
        failures++;
        $display("FAIL bp_stall[%0d] got rdy=%b vld=%b dat=%h tid=%0d exp rdy=0000 vld=1 dat=1234 tid=1", k, sr4, mv4, md4, mt4);
      end
      tick4();
    end
    mr4 = 1'b1;
    #1;
    checks++;
    if (sr4 !== 4'b1000) begin failures++; $display("FAIL bp_release_rdy got=%b exp=1000", sr4); end
    tick4();
    checks++;
    if (mt4 !== 2'd3 || mv4 !== 1'b1) begin failures++; $display("FAIL bp_ch3 got tid=%0d vld=%b exp tid=3 vld=1", mt4, mv4); end
    sv4 = 4'b0001;
    tick4();
    checks++;
    if (mt4 !== 2'd0 || mv4 !== 1'b1) begin failures++; $display("FAIL bp_ch0 got tid=%0d vld=%b exp tid=0 vld=1", mt4, mv4); end
    sv4 = 4'h0;
  endtask

  task automatic test_mask();
    logic [1:0] seq [4];
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3;
    do_reset();
    sv4 = 4'hF; en4 = 4'b1010; mr4 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (sr4[0] !== 1'b0 || sr4[2] !== 1'b0) begin failures++; $display("FAIL mask_rdy[%0d] got=%b exp bits0,2=0", k, sr4); end
      tick4();
      checks++;
      if (mt4 !== ((k % 2 == 0) ? 2'd1 : 2'd3)) begin
        failures++; $display("FAIL mask_tid[%0d] got=%0d exp=%0d", k, mt4, (k % 2 == 0) ? 1 : 3);
      end
    end
    en4 = 4'hF;
    for (int k = 0; k < 4; k++) begin
      tick4();
      checks++;
      if (mt4 !== seq[k]) begin failures++; $display("FAIL unmask_tid[%0d] got=%0d exp=%0d", k, mt4, seq[k]); end
    end
    sv4 = 4'h0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    sv4 = 4'b0010; mr4 = 1'b0; en4 = 4'hF;
    tick4();
    rst = 1'b1; sv4 = 4'hF; mr4 = 1'b1;
    #1;
    checks++;
    if (sr4 !== 4'b0) begin failures++; $display("FAIL rstmid_rdy got=%b exp=0000", sr4); end
    tick4();
    checks++;
    if (mv4 !== 1'b0 || bc4 !== 32'd0) begin failures++; $display("FAIL rstmid_out got vld=%b cnt=%0d exp vld=0 cnt=0", mv4, bc4); end
    rst = 1'b0; sv4 = 4'b0110;
    #1;
    checks++;
    if (sr4 !== 4'b0010) begin failures++; $display("FAIL rstmid_first_rdy got=%b exp=0010", sr4); end
    tick4();
    checks++;
    if (mt4 !== 2'd1 || mv4 !== 1'b1) begin failures++; $display("FAIL rstmid_first_tid got=%0d exp=1", mt4); end
    sv4 = 4'h0;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      sv4 = 4'($urandom);
      en4 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      mr4 = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 59) == 0);
      #1;
      checks++;
      if (sr4 !== m_rdy()) begin failures++; $display("FAIL rand_rdy[%0d] got=%b exp=%b", k, sr4, m_rdy()); end
      tick4();
      checks++;
      if (mv4 !== e_vld || bc4 !== e_cnt || (e_vld && (md4 !== e_dat || mt4 !== 2'(e_tid)))) begin
        failures++;
        $display("FAIL rand_out[%0d] got vld=%b dat=%h tid=%0d cnt=%0d exp vld=%b dat=%h tid=%0d cnt=%0d",
                 k, mv4, md4, mt4, bc4, e_vld, e_dat, e_tid, e_cnt);
      end
    end
    rst = 1'b0; sv4 = 4'h0;
  endtask

  task automatic test_n3();
    sv3 = 3'h7; en3 = 3'h7; mr3 = 1'b1; rst3 = 1'b1;
    for (int k = 0; k < 3; k++) sd3[k*64 +: 64] = 64'(k + 16);
    @(posedge clk); @(posedge clk); #1;
    rst3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checks++;
      if (mv3 !== 1'b1 || mt3 !== 2'(k % 3) || md3 !== 64'(k % 3 + 16)) begin
        failures++; $display("FAIL n3_seq[%0d] got vld=%b tid=%0d dat=%h exp vld=1 tid=%0d", k, mv3, mt3, md3, k % 3);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) sd4[i*64 +: 64] = {$urandom, $urandom};
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_reset_mid();
    test_random();
    test_n3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
